// File: rtl/lbm_bram_streamer_if.sv
// AXI4-Stream beat channel carrying one D2Q9 pixel (nine distribution lanes)
// from the BRAM streamer to the pixel unpacker.
interface lbm_bram_streamer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                      tvalid;
  logic                      tready;
  logic [9*DATA_WIDTH-1:0]   tdata;
  logic [9*DATA_WIDTH/8-1:0] tstrb;
  logic                      tlast;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/lbm_bram_streamer.sv
// Streams one frame of D2Q9 pixels from a 1-cycle-latency BRAM onto AXI4-Stream
// through a 2-entry skid buffer. Optional frame checksum: LBM_STREAM_CHECKSUM_EN.
module lbm_bram_streamer #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                      m00_axis_aclk,
  input  logic                      m00_axis_aresetn,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      bram_en,
  output logic [ADDRESS_WIDTH-1:0]  bram_addr,
  input  logic [9*DATA_WIDTH-1:0]   bram_dout,
  lbm_bram_streamer_if.master       m00_axis,
  output logic [DATA_WIDTH-1:0]     checksum
);
  localparam int BEAT_W = 9 * DATA_WIDTH;
  localparam int STRB_W = BEAT_W / 8;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = {ADDRESS_WIDTH{1'b0}};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t                     state_r, state_s;
  logic [ADDRESS_WIDTH-1:0]   ptr_r, ptr_s, last_addr_r;
  logic                       inflight_r, inflight_last_r;
  logic [BEAT_W-1:0]          buf_data_r [2];
  logic [1:0]                 buf_last_r;
  logic                       wr_sel_r, rd_sel_r;
  logic [1:0]                 occ_r;
  logic [2:0]                 fill_s;
  logic                       pop_s, push_s, issue_s, done_s, accept_s;
  logic                       busy_r, done_r;
  logic [BEAT_W-1:0]          head_data_s;
  logic                       head_last_s, tvalid_s;

  assign tvalid_s    = (occ_r != 2'd0);
  assign head_data_s = buf_data_r[rd_sel_r];
  assign head_last_s = buf_last_r[rd_sel_r];
  assign pop_s       = tvalid_s & m00_axis.tready;
  assign push_s      = inflight_r;
  // Slots already claimed (stored or still in the BRAM pipe) once this cycle's pop leaves
  assign fill_s      = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};

  // Next-state, read issue and frame-completion decode
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    issue_s  = 1'b0;
    done_s   = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s  = ST_RUN;
          ptr_s    = ADDR_ZERO;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (fill_s < 3'd2) begin
          issue_s = 1'b1;
          if (ptr_r == LAST_ADDR) begin
            state_s = ST_DRAIN;
          end else begin
            ptr_s = ptr_r + ADDR_ONE;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (pop_s && head_last_s && !inflight_r && (occ_r == 2'd1)) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Control state, read pointer and registered status flags
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_r         <= ST_IDLE;
      ptr_r           <= ADDR_ZERO;
      last_addr_r     <= ADDR_ZERO;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      state_r         <= state_s;
      ptr_r           <= ptr_s;
      busy_r          <= (state_s != ST_IDLE);
      done_r          <= done_s;
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s & (ptr_r == LAST_ADDR);
      if (issue_s) begin
        last_addr_r <= ptr_r;
      end
    end
  end

  // Two-entry output buffer fed by the BRAM read pipe
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      buf_data_r[0] <= {BEAT_W{1'b0}};
      buf_data_r[1] <= {BEAT_W{1'b0}};
      buf_last_r    <= 2'b00;
      wr_sel_r      <= 1'b0;
      rd_sel_r      <= 1'b0;
      occ_r         <= 2'd0;
    end else begin
      if (push_s) begin
        buf_data_r[wr_sel_r] <= bram_dout;
        buf_last_r[wr_sel_r] <= inflight_last_r;
        wr_sel_r             <= ~wr_sel_r;
      end
      if (pop_s) begin
        rd_sel_r <= ~rd_sel_r;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign bram_en         = issue_s;
  assign bram_addr       = issue_s ? ptr_r : last_addr_r;
  assign m00_axis.tvalid = tvalid_s;
  assign m00_axis.tdata  = head_data_s;
  assign m00_axis.tlast  = tvalid_s & head_last_s;
  assign m00_axis.tstrb  = {STRB_W{1'b1}};

`ifdef LBM_STREAM_CHECKSUM_EN
  function automatic logic [DATA_WIDTH-1:0] lane_sum(input logic [BEAT_W-1:0] beat);
    logic [DATA_WIDTH-1:0] acc;
    acc = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < 9; k++) begin
      acc = acc + beat[k*DATA_WIDTH +: DATA_WIDTH];
    end
    return acc;
  endfunction

  logic [DATA_WIDTH-1:0] checksum_r;

  // Running modular sum of every accepted beat, restarted by each accepted start
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      checksum_r <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      checksum_r <= {DATA_WIDTH{1'b0}};
    end else if (pop_s) begin
      checksum_r <= checksum_r + lane_sum(head_data_s);
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = {DATA_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_lbm_bram_streamer.sv
// Self-checking bench for lbm_bram_streamer: frame-level reference model plus
// directed scenarios (full rate, stall, random backpressure, restart, reset, checksum).
module tb_lbm_bram_streamer;
  localparam int DW    = 16;
  localparam int DEPTH = 2500;
  localparam int AW    = 12;
`ifdef LBM_STREAM_CHECKSUM_EN
  localparam logic [15:0] ONES_CSUM = 16'h57E4;
`else
  localparam logic [15:0] ONES_CSUM = 16'h0000;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [143:0]  bram_dout;
  logic [15:0]   checksum;

  lbm_bram_streamer_if #(.DATA_WIDTH(DW)) m00 ();

  lbm_bram_streamer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .bram_en          (bram_en),
    .bram_addr        (bram_addr),
    .bram_dout        (bram_dout),
    .m00_axis         (m00),
    .checksum         (checksum)
  );

  int checks = 0;
  int errors = 0;

  logic ones_mode = 1'b0;
  logic rand_mode = 1'b0;
  logic tready_hold = 1'b1;

  int next_rd = 0;
  int beats = 0;
  int exp_pix = 0;
  logic [15:0] model_sum = 16'h0000;
  logic [15:0] csum_hold = 16'h0000;
  logic prev_stall = 1'b0;
  logic [143:0] prev_data = 144'd0;
  logic prev_last = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [143:0] pix_beat(input int pix);
    logic [143:0] b;
    for (int k = 0; k < 9; k++) begin
      b[k*16 +: 16] = ones_mode ? 16'd1 : 16'(pix + k);
    end
    return b;
  endfunction

  function automatic logic [15:0] beat_sum(input int pix);
    logic [15:0] s;
    logic [143:0] b;
    b = pix_beat(pix);
    s = 16'h0000;
    for (int k = 0; k < 9; k++) s = s + b[k*16 +: 16];
    return s;
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM with one cycle read latency
  always @(posedge clk) begin
    if (bram_en) bram_dout <= pix_beat(int'(bram_addr));
  end

  // tready driver
  initial begin
    m00.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m00.tready = rand_mode ? 1'($urandom_range(0, 1)) : tready_hold;
    end
  end

  // Reference model and per-cycle compare
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        next_rd = 0; beats = 0; exp_pix = 0; model_sum = 16'h0000;
        csum_hold = 16'h0000; prev_stall = 1'b0;
      end else begin
        if (bram_en) begin
          chk("rd_addr", 144'(bram_addr), 144'(next_rd));
          next_rd++;
        end
        if (prev_stall) begin
          chk("stall_valid", 144'(m00.tvalid), 144'd1);
          chk("stall_data", m00.tdata, prev_data);
          chk("stall_last", 144'(m00.tlast), 144'(prev_last));
        end
        if (m00.tvalid) begin
          chk("tdata", m00.tdata, pix_beat(exp_pix));
          chk("tlast", 144'(m00.tlast), 144'(exp_pix == DEPTH - 1));
          chk("tstrb", 144'(m00.tstrb), 144'h3FFFF);
          if (m00.tready) begin
            model_sum = model_sum + beat_sum(exp_pix);
            exp_pix++;
            beats++;
          end
        end
        if (next_rd - beats > 2) chk("occupancy", 144'(next_rd - beats), 144'd2);
        if (done) begin
          chk("done_beats", 144'(beats), 144'(DEPTH));
          chk("done_busy", 144'(busy), 144'd0);
`ifdef LBM_STREAM_CHECKSUM_EN
          csum_hold = model_sum;
`else
          csum_hold = 16'h0000;
`endif
        end
        if (!busy) chk("csum_idle", 144'(checksum), 144'(csum_hold));
        prev_stall = m00.tvalid & ~m00.tready;
        prev_data  = m00.tdata;
        prev_last  = m00.tlast;
        if (start && !busy) begin
          next_rd = 0; beats = 0; exp_pix = 0; model_sum = 16'h0000;
        end
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (beats < n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (beats < n) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", beats, n);
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 144'(m00.tvalid), 144'd0);
    chk("rst_tlast", 144'(m00.tlast), 144'd0);
    chk("rst_busy", 144'(busy), 144'd0);
    chk("rst_done", 144'(done), 144'd0);
    chk("rst_bram_en", 144'(bram_en), 144'd0);
    chk("rst_bram_addr", 144'(bram_addr), 144'd0);
    chk("rst_checksum", 144'(checksum), 144'd0);
    rst_n = 1'b1;

    // Full rate: latency and DEPTH+2 cycle frame
    start_frame();
    chk("lat_e0", 144'(m00.tvalid), 144'd0);
    @(posedge clk); #1;
    chk("lat_e1", 144'(m00.tvalid), 144'd0);
    @(posedge clk); #1;
    chk("lat_e2", 144'(m00.tvalid), 144'd1);
    chk("first_lane0", 144'(m00.tdata[15:0]), 144'd0);
    chk("first_lane8", 144'(m00.tdata[143:128]), 144'd8);
    wait_done(4000, cyc);
    chk("frame_cycles", 144'(cyc + 2), 144'd2502);
    chk("frame_beats", 144'(beats), 144'd2500);
    chk("busy_at_done", 144'(busy), 144'd0);
    @(posedge clk); #1;
    chk("done_pulse", 144'(done), 144'd0);

    // Stall right after start: only two reads, pixel 0 held
    tready_hold = 1'b0;
    start_frame();
    repeat (20) @(posedge clk);
    #1;
    chk("stall_reads", 144'(next_rd), 144'd2);
    chk("stall_tvalid", 144'(m00.tvalid), 144'd1);
    chk("stall_lane0", 144'(m00.tdata[15:0]), 144'd0);
    chk("stall_bram_en", 144'(bram_en), 144'd0);
    tready_hold = 1'b1;
    wait_done(5000, cyc);

    // Random backpressure
    rand_mode = 1'b1;
    start_frame();
    wait_done(20000, cyc);
    chk("rand_beats", 144'(beats), 144'd2500);
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Start pulsed mid-frame is ignored
    start_frame();
    wait_beats(100, 500);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(5000, cyc);
    chk("restart_beats", 144'(beats), 144'd2500);

    // Reset mid-frame
    start_frame();
    wait_beats(1000, 2000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 144'(m00.tvalid), 144'd0);
    chk("mid_rst_busy", 144'(busy), 144'd0);
    chk("mid_rst_bram_en", 144'(bram_en), 144'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    start_frame();
    cyc = 0;
    while (!m00.tvalid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("post_rst_valid", 144'(m00.tvalid), 144'd1);
    chk("post_rst_lane0", 144'(m00.tdata[15:0]), 144'd0);
    wait_done(5000, cyc);

    // Checksum over an all-ones frame
    ones_mode = 1'b1;
    start_frame();
    wait_done(5000, cyc);
    chk("ones_checksum", 144'(checksum), 144'(ONES_CSUM));
    repeat (5) @(posedge clk);
    #1;
    chk("ones_checksum_hold", 144'(checksum), 144'(ONES_CSUM));
    ones_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
